// File: rtl/inst_buffer.sv
// inst_buffer: first-word-fall-through instruction queue between fetch and decode.
// Optional feature macro INST_BUFFER_BYPASS_EN forwards the write port to the head when the queue is empty.
module inst_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_pc,
    input  logic [INST_WIDTH-1:0] wr_inst,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] d_pc,
    output logic [ADDR_WIDTH-1:0] d_pc4,
    output logic [INST_WIDTH-1:0] d_inst_word,
    output logic                  d_valid,
    output logic                  inst_buffer_empty,
    output logic                  inst_buffer_full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_head_vld;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [INST_WIDTH-1:0] w_head_inst;

    // Status comes from the registered count only, never from the handshake inputs.
    assign inst_buffer_empty = (r_count == '0);
    assign inst_buffer_full  = (r_count == FULL_CNT);
    assign count             = r_count;

`ifdef INST_BUFFER_BYPASS_EN
    assign w_bypass = inst_buffer_empty && wr_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that decode takes immediately is never written to storage.
    assign w_push = wr_valid && !inst_buffer_full && !flush && !(w_bypass && rd_ready);
    assign w_pop  = rd_ready && !inst_buffer_empty && !flush;

    always_comb begin
        w_head_vld  = !inst_buffer_empty;
        w_head_pc   = '0;
        w_head_inst = '0;
        if (w_bypass) begin
            w_head_vld  = 1'b1;
            w_head_pc   = wr_pc;
            w_head_inst = wr_inst;
        end else if (!inst_buffer_empty) begin
            w_head_pc   = r_pc_mem[r_rd_ptr];
            w_head_inst = r_inst_mem[r_rd_ptr];
        end
    end

    assign d_valid     = w_head_vld;
    assign d_pc        = w_head_pc;
    assign d_pc4       = w_head_pc + ADDR_WIDTH'(4);
    assign d_inst_word = w_head_inst;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= wr_pc;
            r_inst_mem[r_wr_ptr] <= wr_inst;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue-based reference model predicts head order and occupancy.
module tb_inst_buffer;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_pc = '0;
    logic [IW-1:0] wr_inst = '0;
    logic          rd_ready = 1'b0;
    logic [AW-1:0] d_pc;
    logic [AW-1:0] d_pc4;
    logic [IW-1:0] d_inst_word;
    logic          d_valid;
    logic          inst_buffer_empty;
    logic          inst_buffer_full;
    logic [$clog2(DEPTH):0] count;

    int tests = 0;
    int fails = 0;

    ent_t exp_q[$];
    int   m_count = 0;
    int   m_next = 0;
    bit   exp_dvalid = 1'b0;
    bit   in_reset_chk = 1'b0;

    inst_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_valid(wr_valid),
        .wr_pc(wr_pc), .wr_inst(wr_inst), .rd_ready(rd_ready),
        .d_pc(d_pc), .d_pc4(d_pc4), .d_inst_word(d_inst_word), .d_valid(d_valid),
        .inst_buffer_empty(inst_buffer_empty), .inst_buffer_full(inst_buffer_full),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model for the coming edge.
    task automatic step(input bit wv, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                        input bit rr, input bit fl);
        int  cur;
        bit  byp;
        bit  acc;
        bit  pop;
        @(posedge clk); #1;
        m_count  = m_next;
        cur      = m_count;
        wr_valid = wv;
        wr_pc    = pc;
        wr_inst  = ins;
        rd_ready = rr;
        flush    = fl;
        byp = 1'b0;
`ifdef INST_BUFFER_BYPASS_EN
        byp = (cur == 0) && wv && !fl;
`endif
        exp_dvalid = (cur > 0) || byp;
        if (fl) begin
            exp_q.delete();
            m_next = 0;
        end else begin
            acc = wv && (cur < DEPTH);
            pop = rr && (cur > 0);
            if (acc) exp_q.push_back('{pc: pc, inst: ins});
            m_next = cur + ((acc && !(byp && rr)) ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clk); #1;
        m_count  = m_next;
        wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
        in_reset_chk = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("async_rst_d_valid", AW'(d_valid), AW'(0));
        chk("async_rst_count", AW'(count), AW'(0));
        chk("async_rst_empty", AW'(inst_buffer_empty), AW'(1));
        chk("async_rst_d_pc4", d_pc4, AW'(4));
        exp_q.delete();
        m_count = 0; m_next = 0; exp_dvalid = 1'b0;
        #1 reset = 1'b1;
        in_reset_chk = 1'b0;
    endtask

    // Monitor: compares status every cycle and the head whenever decode sees a valid word.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (in_reset_chk) continue;
            chk("count", AW'(count), AW'(m_count));
            chk("empty", AW'(inst_buffer_empty), AW'(m_count == 0));
            chk("full", AW'(inst_buffer_full), AW'(m_count == DEPTH));
            chk("d_valid", AW'(d_valid), AW'(exp_dvalid));
            if (exp_dvalid && !flush) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL head_model_empty: d_pc 0x%0h but no entry expected", d_pc);
                end else begin
                    e = exp_q[0];
                    chk("d_pc", d_pc, e.pc);
                    chk("d_pc4", d_pc4, e.pc + AW'(4));
                    chk("d_inst_word", AW'(d_inst_word), AW'(e.inst));
                    if (rd_ready) void'(exp_q.pop_front());
                end
            end else if (!exp_dvalid) begin
                chk("idle_d_pc", d_pc, AW'(0));
                chk("idle_d_pc4", d_pc4, AW'(4));
                chk("idle_d_inst", AW'(d_inst_word), AW'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] pc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Fill to full, then attempt overflow, then drain.
        for (int i = 0; i < 4; i++) step(1, AW'(64'h1000 + 4*i), IW'(32'hA000 + i), 0, 0);
        for (int i = 0; i < 2; i++) step(1, AW'(64'h2000), IW'(32'hDEAD), 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0);
        step(0, '0, '0, 0, 0);

        // Two entries deep, then push+pop every cycle across pointer wrap.
        step(1, AW'(64'h5000), IW'(32'hB000), 0, 0);
        step(1, AW'(64'h5004), IW'(32'hB001), 0, 0);
        for (int i = 2; i < 12; i++) step(1, AW'(64'h5000 + 4*i), IW'(32'hB000 + i), 1, 0);

        // Bring count to 3, then flush against a push and a pop.
        step(1, AW'(64'h5030), IW'(32'hB00C), 0, 0);
        step(1, AW'(64'h3000), IW'(32'hC000), 1, 1);
        step(0, '0, '0, 0, 0);

        // Two entries, then asynchronous reset between edges.
        step(1, AW'(64'h6000), IW'(32'hD000), 0, 0);
        step(1, AW'(64'h6004), IW'(32'hD001), 0, 0);
        step(0, '0, '0, 0, 0);
        async_reset_check();

        // Write into an empty buffer with decode ready.
        step(1, AW'(64'h4000), IW'(32'hE000), 1, 0);
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 1, 0);

        // Randomized traffic, including PC wrap near the top of the address space.
        for (int i = 0; i < 400; i++) begin
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) pc = AW'(64'hFFFF_FFFF_FFFF_FFFC);
            step($urandom_range(0, 3) != 0, pc, IW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, '0, 1, 0);
        step(0, '0, '0, 0, 0);
        @(posedge clk); #1;
        m_count = m_next;
        exp_dvalid = 1'b0;
        @(negedge clk); #1;
        chk("final_model_drained", AW'(exp_q.size()), AW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
